// File: rtl/disp_mux_scan.sv
// Time-multiplexed N-digit seven-segment driver: snapshots the digit vector once
// per frame, rotates a one-hot digit enable and decodes the active digit.
module disp_mux_scan #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int HEX_EN      = 1,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [4*N_DIGITS-1:0]       value,
    input  logic [N_DIGITS-1:0]         dp,
    input  logic                        blank_lz,
    output logic [6:0]                  seg,
    output logic                        dp_o,
    output logic [N_DIGITS-1:0]         an,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx,
    output logic                        frame_done
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]          SEG_INV  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                DP_INV   = (ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_INV   = (ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wrap_q, wrap_d;
    logic [4*N_DIGITS-1:0] val_q, val_d;
    logic [N_DIGITS-1:0]   dpm_q, dpm_d;
    logic                  blz_q, blz_d;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_o_q, dp_o_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic [IDX_W-1:0]      digit_idx_q;
    logic                  frame_done_q, frame_done_d;

    logic [4*N_DIGITS-1:0] cur_val;
    logic [N_DIGITS-1:0]   cur_dp;
    logic                  cur_blz;
    logic                  sof;
    logic                  upper_zero;
    logic [N_DIGITS-1:0]   lz_blank;
    logic [3:0]            nib;
    logic [6:0]            seg_raw;
    logic                  dp_raw;
    logic [N_DIGITS-1:0]   an_raw;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = (HEX_EN != 0) ? 7'h77 : 7'h40;
            4'hB: s = (HEX_EN != 0) ? 7'h7C : 7'h40;
            4'hC: s = (HEX_EN != 0) ? 7'h39 : 7'h40;
            4'hD: s = (HEX_EN != 0) ? 7'h5E : 7'h40;
            4'hE: s = (HEX_EN != 0) ? 7'h79 : 7'h40;
            default: s = (HEX_EN != 0) ? 7'h71 : 7'h40;
        endcase
        return s;
    endfunction

    assign sof = (cnt_q == '0) && (idx_q == '0);

    // Scan position, frame-wrap flag and the per-frame input snapshot.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wrap_d  = wrap_q;
        val_d   = val_q;
        dpm_d   = dpm_q;
        blz_d   = blz_q;
        cur_val = val_q;
        cur_dp  = dpm_q;
        cur_blz = blz_q;
        if (en) begin
            wrap_d = 1'b0;
            if (sof) begin
                val_d   = value;
                dpm_d   = dp;
                blz_d   = blank_lz;
                cur_val = value;
                cur_dp  = dp;
                cur_blz = blank_lz;
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            upper_zero  = upper_zero & (cur_val[4*k +: 4] == 4'h0);
            lz_blank[k] = upper_zero & (k != 0);
        end
        nib     = cur_val[4*idx_q +: 4];
        seg_raw = (cur_blz && lz_blank[idx_q]) ? 7'h00 : decode(nib);
        dp_raw  = cur_dp[idx_q];
        an_raw  = '0;
        an_raw[idx_q] = 1'b1;
        if (!en) begin
            seg_raw = 7'h00;
            dp_raw  = 1'b0;
            an_raw  = '0;
        end
        seg_d        = seg_raw ^ SEG_INV;
        dp_o_d       = dp_raw ^ DP_INV;
        an_d         = an_raw ^ AN_INV;
        frame_done_d = en & wrap_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            wrap_q       <= 1'b0;
            val_q        <= '0;
            dpm_q        <= '0;
            blz_q        <= 1'b0;
            seg_q        <= SEG_INV;
            dp_o_q       <= DP_INV;
            an_q         <= AN_INV;
            digit_idx_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            wrap_q       <= wrap_d;
            val_q        <= val_d;
            dpm_q        <= dpm_d;
            blz_q        <= blz_d;
            seg_q        <= seg_d;
            dp_o_q       <= dp_o_d;
            an_q         <= an_d;
            digit_idx_q  <= idx_q;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp_o       = dp_o_q;
    assign an         = an_q;
    assign digit_idx  = digit_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_mux_scan.sv
// Bench for disp_mux_scan: three instances (hex/active-high, no-hex, active-low) share
// stimulus; a frame-position reference model plus vector table and corner sequences.
module tb_disp_mux_scan;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int F   = N * DIV;

    logic        clk = 1'b0;
    logic        rst_n, en, blank_lz;
    logic [15:0] value;
    logic [3:0]  dp;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dpo_a, dpo_b, dpo_c;
    logic [3:0] an_a, an_b, an_c;
    logic [1:0] di_a, di_b, di_c;
    logic       fd_a, fd_b, fd_c;

    always #5 clk = ~clk;

    disp_mux_scan #(.N_DIGITS(N), .REFRESH_DIV(DIV), .HEX_EN(1), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp), .blank_lz(blank_lz),
        .seg(seg_a), .dp_o(dpo_a), .an(an_a), .digit_idx(di_a), .frame_done(fd_a));
    disp_mux_scan #(.N_DIGITS(N), .REFRESH_DIV(DIV), .HEX_EN(0), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp), .blank_lz(blank_lz),
        .seg(seg_b), .dp_o(dpo_b), .an(an_b), .digit_idx(di_b), .frame_done(fd_b));
    disp_mux_scan #(.N_DIGITS(N), .REFRESH_DIV(DIV), .HEX_EN(1), .ACTIVE_LOW(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp), .blank_lz(blank_lz),
        .seg(seg_c), .dp_o(dpo_c), .an(an_c), .digit_idx(di_c), .frame_done(fd_c));

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: position within the frame counted in enabled cycles since reset.
    int          pos = 0;
    int          tot = 0;
    logic [15:0] snap_v = '0;
    logic [3:0]  snap_dp = '0;
    logic        snap_b = 1'b0;

    function automatic logic [6:0] dec(input logic [3:0] n, input bit hex);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return hex ? 7'h77 : 7'h40;  4'hB: return hex ? 7'h7C : 7'h40;
            4'hC: return hex ? 7'h39 : 7'h40;  4'hD: return hex ? 7'h5E : 7'h40;
            4'hE: return hex ? 7'h79 : 7'h40;  default: return hex ? 7'h71 : 7'h40;
        endcase
    endfunction

    function automatic logic [6:0] seg_of(input logic [15:0] v, input logic b, input int k, input bit hex);
        if (b && k > 0 && (v >> (4 * k)) == 16'd0) return 7'h00;
        return dec(4'((v >> (4 * k)) & 16'hF), hex);
    endfunction

    // One clock: inputs are already applied; sample outputs 1 time unit after the edge.
    task automatic tick();
        logic [6:0] eh, enh;
        logic       edp, efd;
        logic [3:0] ean;
        logic [1:0] edi;
        int         k;
        @(posedge clk);
        #1;
        eh = 7'h00; enh = 7'h00; edp = 1'b0; ean = 4'h0; efd = 1'b0;
        if (!rst_n) begin
            pos = 0; tot = 0; snap_v = '0; snap_dp = '0; snap_b = 1'b0;
            edi = 2'd0;
        end else if (en) begin
            if (pos == 0) begin
                snap_v = value; snap_dp = dp; snap_b = blank_lz;
            end
            k   = pos / DIV;
            eh  = seg_of(snap_v, snap_b, k, 1'b1);
            enh = seg_of(snap_v, snap_b, k, 1'b0);
            edp = snap_dp[k];
            ean = 4'(1 << k);
            efd = (pos == 0) && (tot > 0);
            edi = 2'(k);
            pos = (pos + 1) % F;
            tot++;
        end else begin
            edi = 2'(pos / DIV);
        end
        check("model_hex",    {17'd0, seg_a, dpo_a, an_a, di_a, fd_a}, {17'd0, eh, edp, ean, edi, efd});
        check("model_nohex",  {17'd0, seg_b, dpo_b, an_b, di_b, fd_b}, {17'd0, enh, edp, ean, edi, efd});
        check("model_actlow", {17'd0, seg_c, dpo_c, an_c, di_c, fd_c}, {17'd0, ~eh, ~edp, ~ean, edi, efd});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        blz;
        logic [27:0] exp_seg;  // {d3,d2,d1,d0}, HEX_EN=1
        logic [27:0] exp_nh;   // {d3,d2,d1,d0}, HEX_EN=0
        logic [3:0]  exp_dp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int pulses;
        bit all_off;

        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000};
        vecs[1] = '{16'h00A0, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h77, 7'h3F}, {7'h00, 7'h00, 7'h40, 7'h3F}, 4'b0000};
        vecs[2] = '{16'h0000, 4'b1000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b1000};
        vecs[3] = '{16'hBCDE, 4'b0101, 1'b1, {7'h7C, 7'h39, 7'h5E, 7'h79}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0101};
        vecs[4] = '{16'h0F09, 4'b0000, 1'b1, {7'h00, 7'h71, 7'h3F, 7'h6F}, {7'h00, 7'h40, 7'h3F, 7'h6F}, 4'b0000};
        vecs[5] = '{16'h8765, 4'b0110, 1'b0, {7'h7F, 7'h07, 7'h7D, 7'h6D}, {7'h7F, 7'h07, 7'h7D, 7'h6D}, 4'b0110};

        rst_n = 1'b0; en = 1'b0; value = '0; dp = '0; blank_lz = 1'b0;
        tick();
        tick();
        check("reset_an",       {28'd0, an_a}, 32'h0);
        check("reset_seg",      {25'd0, seg_a}, 32'h0);
        check("reset_fd",       {31'd0, fd_a}, 32'h0);
        check("reset_an_al",    {28'd0, an_c}, 32'hF);
        check("reset_seg_al",   {25'd0, seg_c}, 32'h7F);

        // Vector table: one full frame per record, plus the frame_done pulse that follows.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            value = vecs[i].value; dp = vecs[i].dp; blank_lz = vecs[i].blz; en = 1'b1;
            for (int c = 0; c <= F; c++) begin
                tick();
                if (c < F && c % DIV == 1) begin
                    check("vec_seg",   {25'd0, seg_a}, {25'd0, vecs[i].exp_seg[(c / DIV) * 7 +: 7]});
                    check("vec_seg_nh", {25'd0, seg_b}, {25'd0, vecs[i].exp_nh[(c / DIV) * 7 +: 7]});
                    check("vec_dp",    {31'd0, dpo_a}, {31'd0, vecs[i].exp_dp[c / DIV]});
                end
                if (c == 0) check("vec_fd_first", {31'd0, fd_a}, 32'd0);
                if (c == F) check("vec_fd_pulse", {31'd0, fd_a}, 32'd1);
            end
        end

        // frame_done: exactly one pulse per 16 enabled cycles.
        do_reset();
        value = 16'h1234; dp = '0; blank_lz = 1'b0; en = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3 * F; c++) begin
            tick();
            if (fd_a) pulses++;
        end
        check("fd_count", pulses, 32'd2);

        // Mid-frame input change must not tear the current frame.
        do_reset();
        value = 16'h1111; en = 1'b1;
        for (int c = 0; c <= 8; c++) tick();
        value = 16'h2222;
        for (int c = 9; c <= 17; c++) begin
            tick();
            if (c == 10) check("tear_d2", {25'd0, seg_a}, 32'h06);
            if (c == 14) check("tear_d3", {25'd0, seg_a}, 32'h06);
            if (c == 17) check("tear_next", {25'd0, seg_a}, 32'h5B);
        end

        // en low for 10 cycles in digit 1, then digit 1 finishes its remaining 2 cycles.
        do_reset();
        value = 16'h1234; en = 1'b1;
        for (int c = 0; c <= 5; c++) tick();
        en = 1'b0;
        all_off = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (an_a != 4'h0 || seg_a != 7'h00 || fd_a) all_off = 1'b0;
        end
        check("en_off", {31'd0, all_off}, 32'd1);
        en = 1'b1;
        tick();
        tick();
        check("en_resume_d1", {28'd0, an_a}, 32'h2);
        tick();
        check("en_resume_d2", {28'd0, an_a}, 32'h4);

        // Reset pulse during digit 3 aborts the frame.
        do_reset();
        for (int c = 0; c <= 13; c++) tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid_an", {28'd0, an_a}, 32'h0);
        check("rst_mid_idx", {30'd0, di_a}, 32'h0);
        check("rst_mid_fd", {31'd0, fd_a}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("rst_restart_an", {28'd0, an_a}, 32'h1);
        check("rst_restart_fd", {31'd0, fd_a}, 32'h0);

        // Active-low instance: value 0 with dp on digit 0.
        do_reset();
        value = 16'h0000; dp = 4'b0001; blank_lz = 1'b0;
        tick();
        tick();
        check("al_seg", {25'd0, seg_c}, 32'h40);
        check("al_dp",  {31'd0, dpo_c}, 32'h0);
        check("al_an",  {28'd0, an_c}, 32'hE);

        // Randomised run against the reference model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst_n    = ($urandom_range(0, 149) != 0);
            en       = ($urandom_range(0, 7) != 0);
            value    = 16'($urandom);
            case ($urandom_range(0, 3))
                0: value = value & 16'h00FF;
                1: value = value & 16'h000F;
                2: value = value & 16'h0F0F;
                default: ;
            endcase
            dp       = 4'($urandom);
            blank_lz = 1'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
